// File: rtl/uart_rx_cfg_decoder.sv
// uart_rx_cfg_decoder: 8N1 UART receiver plus command-frame parser.
// Frames are "SYNC op addr [d3 d2 d1 d0] [csum]" and become config-bus strobes.
// Build option: define UART_RX_CFG_CHECKSUM_EN to require a trailing checksum byte
// equal to the XOR of the opcode, address and data bytes.
//
// Output contract: wrStb, rdStb, errStb and rxByteVld are single-cycle pulses
// with no backpressure. addr32 (and i32 for writes) are valid in the strobe
// cycle and hold until the next completed command. errStb never coincides
// with wrStb or rdStb.
module uart_rx_cfg_decoder #(
   parameter int unsigned CLK_DIV   = 87,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 100000
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        uRx,
   output logic [31:0] addr32,
   output logic [31:0] i32,
   output logic        wrStb,
   output logic        rdStb,
   output logic        errStb,
   output logic [7:0]  rxByte,
   output logic        rxByteVld
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_BIT = CW'(CLK_DIV - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [7:0]    OP_WR    = 8'h57;
   localparam logic [7:0]    OP_RD    = 8'h52;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} b_state_t;
`ifdef UART_RX_CFG_CHECKSUM_EN
   typedef enum logic [2:0] {P_SYNC, P_OP, P_ADDR, P_DATA, P_CSUM} p_state_t;
`else
   typedef enum logic [1:0] {P_SYNC, P_OP, P_ADDR, P_DATA} p_state_t;
`endif

   b_state_t      b_state;
   p_state_t      p_state;
   logic [2:0]    sync_q;      // [1] is the synchronised line, [2] its previous value
   logic          rx;
   logic          rx_prev;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          frm_err;     // stop bit sampled low, seen by the parser next cycle
   logic [TW-1:0] to_cnt;
   logic          is_wr;
   logic [1:0]    d_idx;
   logic [7:0]    addr_h;
   logic [23:0]   data_h;      // first three data bytes; byte 3 completes the word
`ifdef UART_RX_CFG_CHECKSUM_EN
   logic [7:0]    data_last;
   logic [7:0]    csum;
`endif

   assign rx      = sync_q[1];
   assign rx_prev = sync_q[2];

   // Two-flop synchroniser plus one history flop for falling-edge detection; idle high.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) sync_q <= 3'b111;
      else       sync_q <= {sync_q[1:0], uRx};
   end

   // Bit engine: finds a start edge, samples each bit at mid-bit, checks the stop bit.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         b_state   <= B_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rxByte    <= '0;
         rxByteVld <= 1'b0;
         frm_err   <= 1'b0;
      end else begin
         rxByteVld <= 1'b0;
         frm_err   <= 1'b0;
         case (b_state)
            B_IDLE: begin
               if (rx_prev && !rx) begin
                  bit_cnt <= HALF_BIT;
                  b_state <= B_START;
               end
            end
            B_START: begin
               if (bit_cnt == '0) begin
                  if (!rx) begin
                     bit_cnt <= FULL_BIT;
                     bit_idx <= '0;
                     b_state <= B_DATA;
                  end else begin
                     b_state <= B_IDLE;  // glitch, not a real start bit
                  end
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            B_DATA: begin
               if (bit_cnt == '0) begin
                  shreg   <= {rx, shreg[7:1]};
                  bit_cnt <= FULL_BIT;
                  if (bit_idx == 3'd7) b_state <= B_STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            B_STOP: begin
               if (bit_cnt == '0) begin
                  if (rx) begin
                     rxByte    <= shreg;
                     rxByteVld <= 1'b1;
                  end else begin
                     frm_err   <= 1'b1;
                  end
                  b_state <= B_IDLE;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            default: b_state <= B_IDLE;
         endcase
      end
   end

   // Frame parser: consumes received bytes, runs the inter-byte timeout, issues strobes.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         p_state   <= P_SYNC;
         to_cnt    <= '0;
         is_wr     <= 1'b0;
         d_idx     <= '0;
         addr_h    <= '0;
         data_h    <= '0;
`ifdef UART_RX_CFG_CHECKSUM_EN
         data_last <= '0;
         csum      <= '0;
`endif
         addr32    <= '0;
         i32       <= '0;
         wrStb     <= 1'b0;
         rdStb     <= 1'b0;
         errStb    <= 1'b0;
      end else begin
         wrStb  <= 1'b0;
         rdStb  <= 1'b0;
         errStb <= 1'b0;
         if (frm_err) begin
            errStb  <= 1'b1;
            p_state <= P_SYNC;
            to_cnt  <= '0;
         end else if (rxByteVld) begin
            // A byte arriving beats a timeout expiring in the same cycle.
            to_cnt <= '0;
            case (p_state)
               P_SYNC: begin
                  if (rxByte == SYNC_BYTE) p_state <= P_OP;
               end
               P_OP: begin
                  if (rxByte == OP_WR || rxByte == OP_RD) begin
                     is_wr   <= (rxByte == OP_WR);
`ifdef UART_RX_CFG_CHECKSUM_EN
                     csum    <= rxByte;
`endif
                     p_state <= P_ADDR;
                  end else begin
                     errStb  <= 1'b1;
                     p_state <= P_SYNC;
                  end
               end
               P_ADDR: begin
                  addr_h <= rxByte;
                  d_idx  <= '0;
`ifdef UART_RX_CFG_CHECKSUM_EN
                  csum   <= csum ^ rxByte;
                  p_state <= is_wr ? P_DATA : P_CSUM;
`else
                  if (is_wr) begin
                     p_state <= P_DATA;
                  end else begin
                     addr32  <= {24'h0, rxByte};
                     rdStb   <= 1'b1;
                     p_state <= P_SYNC;
                  end
`endif
               end
               P_DATA: begin
                  d_idx <= d_idx + 1'b1;
`ifdef UART_RX_CFG_CHECKSUM_EN
                  csum  <= csum ^ rxByte;
`endif
                  if (d_idx == 2'd3) begin
`ifdef UART_RX_CFG_CHECKSUM_EN
                     data_last <= rxByte;
                     p_state   <= P_CSUM;
`else
                     addr32  <= {24'h0, addr_h};
                     i32     <= {data_h, rxByte};
                     wrStb   <= 1'b1;
                     p_state <= P_SYNC;
`endif
                  end else begin
                     data_h <= {data_h[15:0], rxByte};
                  end
               end
`ifdef UART_RX_CFG_CHECKSUM_EN
               P_CSUM: begin
                  if (rxByte == csum) begin
                     addr32 <= {24'h0, addr_h};
                     if (is_wr) begin
                        i32   <= {data_h, data_last};
                        wrStb <= 1'b1;
                     end else begin
                        rdStb <= 1'b1;
                     end
                  end else begin
                     errStb <= 1'b1;
                  end
                  p_state <= P_SYNC;
               end
`endif
               default: p_state <= P_SYNC;
            endcase
         end else if (p_state != P_SYNC) begin
            if (to_cnt == TO_LAST) begin
               errStb  <= 1'b1;
               p_state <= P_SYNC;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg_decoder.sv
// tb_uart_rx_cfg_decoder: table-driven and randomized frames for uart_rx_cfg_decoder,
// checked against a frame-level model of expected strobes (kind, addr32, i32).
// Follows UART_RX_CFG_CHECKSUM_EN: when defined, valid frames carry a checksum byte.
module tb_uart_rx_cfg_decoder;

   localparam int CLK_DIV = 8;
   localparam int TIMEOUT = 200;
   localparam logic [1:0] K_WR  = 2'd1;
   localparam logic [1:0] K_RD  = 2'd2;
   localparam logic [1:0] K_ERR = 2'd3;
`ifdef UART_RX_CFG_CHECKSUM_EN
   localparam bit CSUM_ON = 1'b1;
`else
   localparam bit CSUM_ON = 1'b0;
`endif

   typedef struct {
      logic [63:0] bytes;      // frame bytes, first byte in the top octet
      int          n;
      int          csum_from;  // index of the first byte covered by the checksum
      bit          add_csum;
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;

   logic        clk = 1'b0;
   logic        nRst;
   logic        uRx;
   logic [31:0] addr32;
   logic [31:0] i32;
   logic        wrStb;
   logic        rdStb;
   logic        errStb;
   logic [7:0]  rxByte;
   logic        rxByteVld;

   logic [65:0] exp_q[$];
   logic [65:0] obs_q[$];
   logic [7:0]  tx_q[$];
   int          total = 0;
   int          bad = 0;
   int          vld_cnt = 0;
   int          coinc_cnt = 0;
   int          vld_base = 0;
   int          sent_cnt = 0;
   logic [7:0]  last_sent = 8'h00;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   vec_t        vecs[8];

   uart_rx_cfg_decoder #(
      .CLK_DIV(CLK_DIV),
      .SYNC_BYTE(8'hA5),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .nRst(nRst),
      .uRx(uRx),
      .addr32(addr32),
      .i32(i32),
      .wrStb(wrStb),
      .rdStb(rdStb),
      .errStb(errStb),
      .rxByte(rxByte),
      .rxByteVld(rxByteVld)
   );

   // Clock and reset are driven from the main sequence below.
   always #5 clk = ~clk;

   // Monitor: records every strobe with the bus values seen in that cycle.
   always @(negedge clk) begin
      if (wrStb)     obs_q.push_back({K_WR, addr32, i32});
      if (rdStb)     obs_q.push_back({K_RD, addr32, i32});
      if (errStb)    obs_q.push_back({K_ERR, addr32, i32});
      if (rxByteVld) vld_cnt++;
      if ((wrStb && rdStb) || ((wrStb || rdStb) && errStb)) coinc_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
      uRx = 1'b0;
      tick(CLK_DIV);
      for (int i = 0; i < 8; i++) begin
         uRx = b[i];
         tick(CLK_DIV);
      end
      uRx = stop;
      tick(CLK_DIV);
      uRx = 1'b1;
      tick(gap);
   endtask

   task automatic load_q(input logic [63:0] v, input int n);
      tx_q.delete();
      for (int j = 0; j < n; j++) tx_q.push_back(v[63-8*j -: 8]);
   endtask

   task automatic send_q(input int csum_from, input bit add_csum, input int max_gap);
      logic [7:0] cs;
      cs = 8'h00;
      sent_cnt = 0;
      foreach (tx_q[i]) begin
         if (i >= csum_from) cs = cs ^ tx_q[i];
         send_byte(tx_q[i], 1'b1, $urandom_range(0, max_gap));
         last_sent = tx_q[i];
         sent_cnt++;
      end
      if (add_csum && CSUM_ON) begin
         send_byte(cs, 1'b1, 0);
         last_sent = cs;
         sent_cnt++;
      end
   endtask

   task automatic expect_evt(input logic [1:0] kind);
      exp_q.push_back({kind, m_addr, m_data});
   endtask

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic check(input string name, input int exp_vld, input logic [7:0] exp_last);
      logic [65:0] e;
      logic [65:0] o;
      int          got_vld;
      tick(40);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (obs_q.size() == 0) begin
            bad++;
            $display("FAIL %s event: got none want kind=%0d addr=%h data=%h",
                     name, e[65:64], e[63:32], e[31:0]);
         end else begin
            o = obs_q.pop_front();
            if (o !== e) begin
               bad++;
               $display("FAIL %s event: got kind=%0d addr=%h data=%h want kind=%0d addr=%h data=%h",
                        name, o[65:64], o[63:32], o[31:0], e[65:64], e[63:32], e[31:0]);
            end
         end
      end
      total++;
      if (obs_q.size() != 0) begin
         bad++;
         $display("FAIL %s extra events: got %0d want 0", name, obs_q.size());
         obs_q.delete();
      end
      got_vld  = vld_cnt - vld_base;
      vld_base = vld_cnt;
      check_eq({name, " rxByteVld count"}, got_vld, exp_vld);
      if (exp_vld > 0) check_eq({name, " rxByte"}, {24'h0, rxByte}, {24'h0, exp_last});
   endtask

   task automatic check_all_zero(input string name);
      check_eq({name, " addr32"}, addr32, 32'h0);
      check_eq({name, " i32"}, i32, 32'h0);
      check_eq({name, " strobes"}, {29'h0, wrStb, rdStb, errStb}, 32'h0);
      check_eq({name, " rxByte"}, {24'h0, rxByte}, 32'h0);
      check_eq({name, " rxByteVld"}, {31'h0, rxByteVld}, 32'h0);
   endtask

   initial begin
      int fe_cnt;
      nRst   = 1'b0;
      uRx    = 1'b1;
      m_addr = 32'h0;
      m_data = 32'h0;
      tick(5);
      check_all_zero("reset");
      nRst = 1'b1;
      tick(10);

      // Directed frames with their expected strobe.
      vecs[0] = '{64'hA557_1012_3456_7800, 7, 1, 1'b1, K_WR,  32'h10, 32'h12345678};
      vecs[1] = '{64'h00FF_A552_3C00_0000, 5, 3, 1'b1, K_RD,  32'h3C, 32'h12345678};
      vecs[2] = '{64'hA5A5_0000_0000_0000, 2, 1, 1'b0, K_ERR, 32'h3C, 32'h12345678};
      vecs[3] = '{64'hA513_0000_0000_0000, 2, 1, 1'b0, K_ERR, 32'h3C, 32'h12345678};
      vecs[4] = '{64'hA552_FF00_0000_0000, 3, 1, 1'b1, K_RD,  32'hFF, 32'h12345678};
      vecs[5] = '{64'hA557_0000_0000_0000, 7, 1, 1'b1, K_WR,  32'h00, 32'h00000000};
      vecs[6] = '{64'h5AA5_57A5_FFFF_FFFF, 8, 2, 1'b1, K_WR,  32'hA5, 32'hFFFFFFFF};
      vecs[7] = '{64'hA552_1200_0000_0000, 3, 1, 1'b1, K_RD,  32'h12, 32'hFFFFFFFF};
      for (int i = 0; i < 8; i++) begin
         load_q(vecs[i].bytes, vecs[i].n);
         send_q(vecs[i].csum_from, vecs[i].add_csum, 6);
         m_addr = vecs[i].addr;
         m_data = vecs[i].data;
         expect_evt(vecs[i].kind);
         check($sformatf("vec%0d", i), sent_cnt, last_sent);
      end

      // Framing error in the middle of a frame, then a clean read.
      load_q(64'hA557_0000_0000_0000, 2);
      send_q(1, 1'b0, 4);
      fe_cnt = sent_cnt;
      send_byte(8'h33, 1'b0, 10);
      expect_evt(K_ERR);
      load_q(64'hA552_0100_0000_0000, 3);
      send_q(1, 1'b1, 4);
      m_addr = 32'h01;
      expect_evt(K_RD);
      check("frame_err", fe_cnt + sent_cnt, last_sent);

      // Short glitch must be rejected as a false start.
      uRx = 1'b0;
      tick(2);
      uRx = 1'b1;
      tick(20);
      check("glitch", 0, 8'h00);

      // Partial frame then silence: timeout abort, then a good write.
      load_q(64'hA557_1000_0000_0000, 3);
      send_q(1, 1'b0, 4);
      tick(TIMEOUT + 60);
      expect_evt(K_ERR);
      check("timeout", sent_cnt, 8'h10);
      load_q(64'hA557_44DE_ADBE_EF00, 7);
      send_q(1, 1'b1, 4);
      m_addr = 32'h44;
      m_data = 32'hDEADBEEF;
      expect_evt(K_WR);
      check("after_timeout", sent_cnt, last_sent);

`ifdef UART_RX_CFG_CHECKSUM_EN
      load_q(64'hA557_2000_0000_0572, 8);
      send_q(1, 1'b0, 4);
      m_addr = 32'h20;
      m_data = 32'h5;
      expect_evt(K_WR);
      check("csum_ok", sent_cnt, 8'h72);
      load_q(64'hA557_2000_0000_0573, 8);
      send_q(1, 1'b0, 4);
      expect_evt(K_ERR);
      check("csum_bad", sent_cnt, 8'h73);
`endif

      // Randomized frames against the frame-level model.
      for (int t = 0; t < 24; t++) begin
         int          kind;
         int          ng;
         logic [7:0]  a;
         logic [7:0]  op;
         logic [7:0]  cs;
         logic [31:0] d;
         kind = $urandom_range(0, 9);
         ng   = $urandom_range(0, 2);
         a    = 8'($urandom_range(0, 255));
         d    = $urandom;
         tx_q.delete();
         for (int g = 0; g < ng; g++) begin
            op = 8'($urandom_range(0, 255));
            if (op == 8'hA5) op = 8'h00;
            tx_q.push_back(op);
         end
         tx_q.push_back(8'hA5);
         if (kind <= 3) begin
            tx_q.push_back(8'h57);
            tx_q.push_back(a);
            tx_q.push_back(d[31:24]);
            tx_q.push_back(d[23:16]);
            tx_q.push_back(d[15:8]);
            tx_q.push_back(d[7:0]);
            send_q(ng + 1, 1'b1, 15);
            m_addr = {24'h0, a};
            m_data = d;
            expect_evt(K_WR);
         end else if (kind == 8) begin
            op = 8'($urandom_range(0, 255));
            if (op == 8'h57 || op == 8'h52) op = 8'h00;
            tx_q.push_back(op);
            send_q(ng + 1, 1'b0, 15);
            expect_evt(K_ERR);
         end else if (kind == 9 && CSUM_ON) begin
            tx_q.push_back(8'h57);
            tx_q.push_back(a);
            tx_q.push_back(d[31:24]);
            tx_q.push_back(d[23:16]);
            tx_q.push_back(d[15:8]);
            tx_q.push_back(d[7:0]);
            send_q(ng + 1, 1'b0, 15);
            cs = 8'h57 ^ a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
            cs = cs ^ 8'($urandom_range(1, 255));
            send_byte(cs, 1'b1, 0);
            last_sent = cs;
            sent_cnt++;
            expect_evt(K_ERR);
         end else begin
            tx_q.push_back(8'h52);
            tx_q.push_back(a);
            send_q(ng + 1, 1'b1, 15);
            m_addr = {24'h0, a};
            expect_evt(K_RD);
         end
         check($sformatf("rand%0d", t), sent_cnt, last_sent);
      end

      // Reset during bit 2 of the address byte abandons the frame.
      load_q(64'hA552_0000_0000_0000, 2);
      send_q(1, 1'b0, 4);
      check("rst_pre", sent_cnt, 8'h52);
      uRx = 1'b0;
      tick(CLK_DIV);
      uRx = 1'b1;
      tick(CLK_DIV);
      uRx = 1'b0;
      tick(CLK_DIV);
      uRx = 1'b1;
      tick(CLK_DIV / 2);
      nRst = 1'b0;
      tick(1);
      check_all_zero("mid_reset");
      uRx = 1'b1;
      tick(4);
      nRst = 1'b1;
      tick(10);
      m_addr = 32'h0;
      m_data = 32'h0;
      load_q(64'hA552_0700_0000_0000, 3);
      send_q(1, 1'b1, 4);
      m_addr = 32'h07;
      expect_evt(K_RD);
      check("after_reset", sent_cnt, last_sent);

      check_eq("strobe coincidence", coinc_cnt, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
